// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO pair; shift-add multiply, restoring divide.
// Ports: clk, reset, start/op/a/b issue, hi_we/lo_we/wdata moves, rd_hilo, busy/done/stall, hi/lo.
// Optional MULDIV_EARLY_OUT_EN: multiply exits once the remaining multiplier bits are zero.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_hilo,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   opb;
   logic [WIDTH-1:0]   a_raw;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic               div0;

   logic               sgn;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_diff;
   logic               div_ok;
   logic [WIDTH-1:0]   rem_next;
   logic [WIDTH-1:0]   quo_next;
   logic               run_exit;

   logic [2*WIDTH-1:0] prod_al;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign busy  = (state != S_IDLE);
   assign stall = busy & (start | rd_hilo | hi_we | lo_we);

   // op[0] set means unsigned
   assign sgn   = ~op[0];
   assign a_neg = sgn & a[WIDTH-1];
   assign b_neg = sgn & b[WIDTH-1];
   assign a_mag = a_neg ? (~a + 1'b1) : a;
   assign b_mag = b_neg ? (~b + 1'b1) : b;

   // multiply step: add multiplicand into the top half, then shift right
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (opb[0] ? mcand : {WIDTH{1'b0}})};
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   // divide step: bit WIDTH of the difference is the borrow
   assign div_sh   = {rem, acc[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, opb};
   assign div_ok   = ~div_diff[WIDTH];
   assign rem_next = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
   assign quo_next = {acc[WIDTH-2:0], div_ok};

`ifdef MULDIV_EARLY_OUT_EN
   assign run_exit = (cnt == '0) | (~is_div & (opb == '0));
   // skipped iterations would only have shifted right
   assign prod_al  = acc >> cnt;
`else
   assign run_exit = (cnt == '0);
   assign prod_al  = acc;
`endif

   assign prod_fix = neg_q ? (~prod_al + 1'b1) : prod_al;
   assign quo_fix  = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
   assign rem_fix  = neg_r ? (~rem + 1'b1) : rem;

   always_ff @(posedge clk) begin
      done <= 1'b0;
      if (reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         acc    <= '0;
         rem    <= '0;
         mcand  <= '0;
         opb    <= '0;
         a_raw  <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state  <= S_RUN;
                  cnt    <= CW'(WIDTH);
                  is_div <= op[1];
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  div0   <= op[1] & (b == '0);
                  a_raw  <= a;
                  mcand  <= a_mag;
                  opb    <= b_mag;
                  rem    <= '0;
                  acc    <= op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            S_RUN: begin
               if (run_exit) begin
                  state <= S_FIX;
               end else begin
                  cnt <= cnt - CW'(1);
                  if (is_div) begin
                     acc[WIDTH-1:0] <= quo_next;
                     rem            <= rem_next;
                  end else begin
                     acc <= mul_next;
                     opb <= opb >> 1;
                  end
               end
            end
            S_FIX: begin
               state <= S_IDLE;
               done  <= 1'b1;
               if (is_div) begin
                  if (div0) begin
                     lo <= '1;
                     hi <= a_raw;
                  end else begin
                     lo <= quo_fix;
                     hi <= rem_fix;
                  end
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus random ops
// against an arithmetic reference model.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        rd_hilo;
   logic        busy;
   logic        done;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int tests = 0;
   int fails = 0;
   logic busy_ok;

   always #5 clk = ~clk;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we),
      .wdata(wdata), .rd_hilo(rd_hilo), .busy(busy),
      .done(done), .stall(stall), .hi(hi), .lo(lo)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // {hi, lo} expected for an operation
   function automatic logic [63:0] model(input logic [1:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] p, qq, rr;
      sx = $signed(x);
      sy = $signed(y);
      case (o)
         2'd0: begin p = sx * sy; return p; end
         2'd1: begin p = {32'b0, x} * {32'b0, y}; return p; end
         default: begin
            if (y == 0) return {x, 32'hFFFFFFFF};
            if (o == 2'd2) begin
               q = sx / sy; r = sx % sy;
               qq = q; rr = r;
               return {rr[31:0], qq[31:0]};
            end
            return {x % y, x / y};
         end
      endcase
   endfunction

   function automatic int lat(input logic [1:0] o, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
      logic [31:0] m;
      int k;
      if (!o[1]) begin
         m = (o == 2'd0 && y[31]) ? -y : y;
         k = 0;
         for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
         return k + 2;
      end
`endif
      return o == 2'd3 ? 34 : 34 + 0 * int'(y[0]);
   endfunction

   task automatic issue(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic w);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      hi_we = w; wdata = 32'hDEAD0000;
      @(posedge clk);
      #1;
      start = 1'b0; hi_we = 1'b0;
      op = 2'($urandom); a = $urandom; b = $urandom;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      busy_ok = 1'b1;
      while (!done && n < 200) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic run_check(input string tag, input logic [1:0] o,
                            input logic [31:0] x, input logic [31:0] y);
      logic [63:0] e;
      int n;
      e = model(o, x, y);
      issue(o, x, y, 1'b0);
      wait_done(n);
      chk({tag, ".lat"}, 64'(n), 64'(lat(o, y)));
      chk({tag, ".busy"}, {63'b0, busy_ok}, 64'd1);
      chk({tag, ".hi"}, {32'b0, hi}, {32'b0, e[63:32]});
      chk({tag, ".lo"}, {32'b0, lo}, {32'b0, e[31:0]});
      chk({tag, ".idle"}, {63'b0, busy}, 64'd0);
   endtask

   initial begin
      logic [63:0] e;
      logic [1:0]  ro;
      logic [31:0] rx, ry;
      logic        saw;
      int          n;

      reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0; rd_hilo = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.busy", {63'b0, busy}, 64'd0);
      chk("rst.done", {63'b0, done}, 64'd0);
      chk("rst.stall", {63'b0, stall}, 64'd0);
      chk("rst.hi", {32'b0, hi}, 64'd0);
      chk("rst.lo", {32'b0, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      run_check("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("multu_max.hi_c", {32'b0, hi}, 64'hFFFFFFFE);
      run_check("mult_neg", 2'd0, 32'hFFFFFFFD, 32'd7);
      chk("mult_neg.lo_c", {32'b0, lo}, 64'hFFFFFFEB);
      run_check("div_neg", 2'd2, 32'hFFFFFFF9, 32'd2);
      chk("div_neg.lo_c", {32'b0, lo}, 64'hFFFFFFFD);
      run_check("divu", 2'd3, 32'd100, 32'd7);
      chk("divu.lo_c", {32'b0, lo}, 64'd14);
      run_check("divu0", 2'd3, 32'd5, 32'd0);
      run_check("div0_neg", 2'd2, 32'hFFFFFF00, 32'd0);
      chk("div0_neg.hi_c", {32'b0, hi}, 64'hFFFFFF00);
      run_check("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF);
      chk("div_ovf.lo_c", {32'b0, lo}, 64'h80000000);
      run_check("mult_b0", 2'd0, 32'h12345678, 32'd0);

      // HI/LO accesses colliding with an operation in flight
      e = model(2'd3, 32'd100, 32'd7);
      issue(2'd3, 32'd100, 32'd7, 1'b0);
      @(negedge clk);
      rd_hilo = 1'b1;
      #1 chk("col.rd", {63'b0, stall}, 64'd1);
      @(negedge clk);
      rd_hilo = 1'b0; start = 1'b1; op = 2'd1;
      a = 32'h55555555; b = 32'h3;
      #1 chk("col.start", {63'b0, stall}, 64'd1);
      @(negedge clk);
      start = 1'b0; hi_we = 1'b1; wdata = 32'h1234;
      #1 chk("col.we", {63'b0, stall}, 64'd1);
      @(negedge clk);
      hi_we = 1'b0;
      #1 chk("col.free", {63'b0, stall}, 64'd0);
      wait_done(n);
      chk("col.hi", {32'b0, hi}, {32'b0, e[63:32]});
      chk("col.lo", {32'b0, lo}, {32'b0, e[31:0]});
      @(posedge clk);
      #1 chk("col.hi_n1234", {63'b0, hi != 32'h1234}, 64'd1);
      chk("col.still_idle", {63'b0, busy}, 64'd0);

      // idle moves to HI/LO
      @(negedge clk);
      hi_we = 1'b1; wdata = 32'h00001234;
      #1 chk("mt.stall", {63'b0, stall}, 64'd0);
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hCAFE0000;
      @(negedge clk);
      lo_we = 1'b0;
      #1;
      chk("mt.hi", {32'b0, hi}, 64'h00001234);
      chk("mt.lo", {32'b0, lo}, 64'hCAFE0000);
      @(negedge clk);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BADF00D;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      #1;
      chk("mt.both_hi", {32'b0, hi}, 64'h0BADF00D);
      chk("mt.both_lo", {32'b0, lo}, 64'h0BADF00D);

      // start and mthi in one cycle: start wins
      issue(2'd3, 32'd100, 32'd7, 1'b1);
      chk("sw.hold", {32'b0, hi}, 64'h0BADF00D);
      wait_done(n);
      chk("sw.hi", {32'b0, hi}, 64'd2);
      chk("sw.lo", {32'b0, lo}, 64'd14);

      // reset in the middle of an operation
      issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst.busy", {63'b0, busy}, 64'd0);
      chk("mrst.hi", {32'b0, hi}, 64'd0);
      chk("mrst.lo", {32'b0, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 if (done) saw = 1'b1;
      end
      chk("mrst.no_done", {63'b0, saw}, 64'd0);
      run_check("mrst.after", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);

      // random back-to-back operations
      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom_range(0, 3));
         rx = $urandom;
         case ($urandom_range(0, 4))
            0: ry = 32'd0;
            1: ry = $urandom_range(1, 15);
            2: ry = -$urandom_range(1, 15);
            default: ry = $urandom;
         endcase
         run_check($sformatf("rnd%0d", i), ro, rx, ry);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
